mem_bus_arbiter: RTL

- Shares one Avalon-style memory port between the CPU's instruction-fetch requester and its data (load/store) requester.
- Sits between the core's split instr_*/data_* interfaces and the single memory bus.
- Sequences one transfer at a time, honours mem_waitrequest, and latches read data.
- Signals completion to each requester with a one-cycle pulse.

---
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single Avalon-style
// memory port. One transfer in flight at a time; all outputs registered.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic [DATA_W-1:0]   instr_rdata,
  output logic                instr_valid,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_byteenable,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t state, state_next;
  state_t last_grant;
  logic   grant_fetch, grant_data, accept, data_pending;

  assign data_pending = data_read | data_write;

  always_comb begin
    state_next  = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        // On contention the side not served last wins, so neither starves.
        if (instr_req && data_pending) begin
          if (last_grant == DATA) grant_fetch = 1'b1;
          else                    grant_data  = 1'b1;
        end else if (instr_req) begin
          grant_fetch = 1'b1;
        end else if (data_pending) begin
          grant_data = 1'b1;
        end
        if (grant_fetch) state_next = FETCH;
        if (grant_data)  state_next = DATA;
      end
      FETCH, DATA: begin
        if (!mem_waitrequest) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      instr_rdata    <= '0;
      data_rdata     <= '0;
      instr_valid    <= 1'b0;
      data_done      <= 1'b0;
      last_grant     <= FETCH;
    end else begin
      instr_valid <= 1'b0;
      data_done   <= 1'b0;
      if (grant_fetch) begin
        mem_address    <= instr_addr;
        mem_byteenable <= '1;
        mem_read       <= 1'b1;
        mem_write      <= 1'b0;
        last_grant     <= FETCH;
      end
      if (grant_data) begin
        // Read+write together is treated as a write.
        mem_address    <= data_addr;
        mem_byteenable <= data_byteenable;
        mem_writedata  <= data_wdata;
        mem_write      <= data_write;
        mem_read       <= ~data_write;
        last_grant     <= DATA;
      end
      if (accept) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (state == FETCH) begin
          instr_rdata <= mem_readdata;
          instr_valid <= 1'b1;
        end else begin
          if (mem_read) data_rdata <= mem_readdata;
          data_done <= 1'b1;
        end
      end
    end
  end

endmodule
